// File: rtl/mad_inverse_divider.sv
// mad_inverse_divider
//   Inverse of the multiply-add stage DATA = A*B + C. Recovers
//   QUOT = (DATA_IN - C) / B and REM = (DATA_IN - C) % B with an iterative
//   restoring divider that produces one quotient bit per clock.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears everything, aborts work
//   start      in   request, sampled only while idle
//   DATA_IN    in   dividend source (packed A*B+C)
//   B          in   divisor
//   C          in   offset subtracted before dividing
//   busy       out  high from the accepted start until done
//   done       out  one-cycle pulse; results valid from this cycle
//   QUOT       out  quotient (never truncated to SIZE_A)
//   REM        out  remainder
//   err_div0   out  B was zero
//   err_under  out  DATA_IN < C
//   exact      out  only with MAD_INV_EXACT_EN defined: DATA_IN is a valid
//                   A*B+C encoding for the given B and C
//
// Build option: define MAD_INV_EXACT_EN to add the `exact` output.
module mad_inverse_divider #(
    parameter int SIZE_A        = 8,
    parameter int SIZE_B        = 8,
    parameter int SIZE_C        = 8,
    parameter int SIZE_DATA_OUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SIZE_DATA_OUT-1:0] DATA_IN,
    input  logic [SIZE_B-1:0]        B,
    input  logic [SIZE_C-1:0]        C,
    output logic                     busy,
    output logic                     done,
    output logic [SIZE_DATA_OUT-1:0] QUOT,
    output logic [SIZE_B-1:0]        REM,
    output logic                     err_div0,
`ifdef MAD_INV_EXACT_EN
    output logic                     exact,
`endif
    output logic                     err_under
);

    localparam int W  = SIZE_DATA_OUT;
    localparam int CW = $clog2(SIZE_DATA_OUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q;
    logic [W-1:0]      data_q;
    logic [SIZE_B-1:0] b_q;
    logic [SIZE_C-1:0] c_q;
    logic [W-1:0]      d_q;      // remaining dividend bits, consumed MSB first
    logic [SIZE_B-1:0] pr_q;     // partial remainder (always < B between steps)
    logic [W-1:0]      qt_q;     // quotient being assembled
    logic [CW-1:0]     cnt_q;
    logic              div0_q;
    logic              under_q;

    logic              busy_q;
    logic              done_q;
    logic [W-1:0]      quot_q;
    logic [SIZE_B-1:0] rem_q;
    logic              err_div0_q;
    logic              err_under_q;

    // Offset removal: the extra MSB is the borrow flag.
    logic [W:0] diff_d;
    assign diff_d = {1'b0, data_q} - {{(W + 1 - SIZE_C){1'b0}}, c_q};

    // One restoring step. The subtraction can be done in SIZE_B bits because
    // whenever it is taken the true result is already below B.
    logic [SIZE_B:0]   pr_shift_d;
    logic              qbit_d;
    logic [SIZE_B-1:0] pr_d;
    assign pr_shift_d = {pr_q, d_q[W-1]};
    assign qbit_d     = (pr_shift_d >= {1'b0, b_q});
    assign pr_d       = qbit_d ? (pr_shift_d[SIZE_B-1:0] - b_q) : pr_shift_d[SIZE_B-1:0];

`ifdef MAD_INV_EXACT_EN
    logic exact_q;
    logic exact_d;
    assign exact_d = !div0_q && !under_q && (pr_q == '0) && ((qt_q >> SIZE_A) == '0);
    assign exact   = exact_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            pr_q        <= '0;
            qt_q        <= '0;
            cnt_q       <= '0;
            div0_q      <= 1'b0;
            under_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_div0_q  <= 1'b0;
            err_under_q <= 1'b0;
`ifdef MAD_INV_EXACT_EN
            exact_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        data_q      <= DATA_IN;
                        b_q         <= B;
                        c_q         <= C;
                        busy_q      <= 1'b1;
                        err_div0_q  <= 1'b0;
                        err_under_q <= 1'b0;
                        state_q     <= S_SUB;
                    end
                end
                S_SUB: begin
                    div0_q  <= 1'b0;
                    under_q <= 1'b0;
                    if (diff_d[W]) begin
                        under_q <= 1'b1;
                        qt_q    <= '0;
                        pr_q    <= '0;
                        state_q <= S_DONE;
                    end else if (b_q == '0) begin
                        div0_q  <= 1'b1;
                        qt_q    <= '1;
                        pr_q    <= diff_d[SIZE_B-1:0];
                        state_q <= S_DONE;
                    end else begin
                        d_q     <= diff_d[W-1:0];
                        pr_q    <= '0;
                        qt_q    <= '0;
                        cnt_q   <= CW'(SIZE_DATA_OUT);
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    pr_q  <= pr_d;
                    qt_q  <= {qt_q[W-2:0], qbit_d};
                    d_q   <= {d_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    // S_DONE: publish results for one done pulse.
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    quot_q      <= qt_q;
                    rem_q       <= pr_q;
                    err_div0_q  <= div0_q;
                    err_under_q <= under_q;
`ifdef MAD_INV_EXACT_EN
                    exact_q     <= exact_d;
`endif
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign QUOT      = quot_q;
    assign REM       = rem_q;
    assign err_div0  = err_div0_q;
    assign err_under = err_under_q;

endmodule

// File: tb/tb_mad_inverse_divider.sv
// Testbench for mad_inverse_divider: directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_mad_inverse_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic [7:0]  B = '0;
    logic [7:0]  C = '0;
    logic        busy, done, err_div0, err_under;
    logic [15:0] QUOT;
    logic [7:0]  REM;
`ifdef MAD_INV_EXACT_EN
    logic        exact;
`endif

    int vectors = 0;
    int miscompares = 0;

    mad_inverse_divider dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .DATA_IN  (DATA_IN),
        .B        (B),
        .C        (C),
        .busy     (busy),
        .done     (done),
        .QUOT     (QUOT),
        .REM      (REM),
        .err_div0 (err_div0),
`ifdef MAD_INV_EXACT_EN
        .exact    (exact),
`endif
        .err_under(err_under)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one division and compare against plain arithmetic on the operands.
    task automatic run_op(input int d, input int b, input int c);
        int n;
        int exp_q, exp_r, exp_lat;
        bit exp_z, exp_u, exp_x;
        DATA_IN = 16'(d);
        B       = 8'(b);
        C       = 8'(c);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        // Inputs must be ignored once accepted.
        DATA_IN = 16'($urandom);
        B       = 8'($urandom);
        C       = 8'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("errs_cleared", 32'({err_div0, err_under}), 32'd0);

        exp_u = (d < c);
        exp_z = !exp_u && (b == 0);
        if (exp_u) begin
            exp_q = 0; exp_r = 0; exp_lat = 2;
        end else if (exp_z) begin
            exp_q = 65535; exp_r = (d - c) % 256; exp_lat = 2;
        end else begin
            exp_q = (d - c) / b; exp_r = (d - c) % b; exp_lat = 18;
        end
        exp_x = !exp_u && !exp_z && (exp_r == 0) && (exp_q <= 255);

        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
        check("done_latency", 32'(n), 32'(exp_lat));
        check("quot", 32'(QUOT), 32'(exp_q));
        check("rem", 32'(REM), 32'(exp_r));
        check("err_div0", 32'(err_div0), 32'(exp_z));
        check("err_under", 32'(err_under), 32'(exp_u));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef MAD_INV_EXACT_EN
        check("exact", 32'(exact), 32'(exp_x));
`endif
        @(posedge clk); #1;
        check("done_pulse_end", 32'(done), 32'd0);
        check("quot_hold", 32'(QUOT), 32'(exp_q));
    endtask

    initial begin
        int dones;
        int a, bb, cc, dd, mode;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(QUOT), 32'd0);
        check("rst_rem", 32'(REM), 32'd0);
        check("rst_errs", 32'({err_div0, err_under}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        run_op(464, 34, 56);
        run_op(1000, 7, 5);
        run_op(65535, 1, 0);
        run_op(50, 0, 8);
        run_op(3, 5, 10);
        run_op(0, 0, 0);
        run_op(255, 255, 255);

        // Randomized operands
        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 4);
            bb = $urandom_range(1, 255);
            cc = $urandom_range(0, 255);
            dd = $urandom_range(0, 65535);
            case (mode)
                0: begin
                    a = $urandom_range(0, 255);
                    dd = a * bb + cc;
                end
                1: bb = 0;
                2: dd = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(dd, bb, cc);
        end

        // Leave nonzero results before the abort scenario.
        run_op(1000, 7, 5);

        // Abort: start, ignored start while busy, then reset mid-operation.
        DATA_IN = 16'd1000; B = 8'd7; C = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        DATA_IN = 16'd464; B = 8'd34; C = 8'd56;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", 32'(QUOT), 32'd0);
        check("abort_rem", 32'(REM), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(464, 34, 56);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
